// File: rtl/aes_link_pkg.sv
// aes_link_pkg: states, key-size codes, command layout and status codes
// shared by the AES SPI sequencer and its watchdog.
package aes_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEXT,
        ST_CMD,
        ST_KEY,
        ST_RECV,
        ST_RESP
    } state_t;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;
    localparam logic [1:0] KS_BAD = 2'b11;

    localparam logic [5:0] KEY_BYTES_128 = 6'd16;
    localparam logic [5:0] KEY_BYTES_192 = 6'd24;
    localparam logic [5:0] KEY_BYTES_256 = 6'd32;

    localparam int CMD_DECRYPT_BIT = 7;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_KEYSIZE = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic [5:0] key_bytes(input logic [1:0] ks);
        logic [5:0] kb;
        kb = KEY_BYTES_128;
        case (ks)
            KS_192:  kb = KEY_BYTES_192;
            KS_256:  kb = KEY_BYTES_256;
            default: kb = KEY_BYTES_128;
        endcase
        return kb;
    endfunction

    function automatic logic [7:0] cmd_byte(input logic dec, input logic [5:0] kb);
        logic [7:0] c;
        c = {2'b00, kb};
        c[CMD_DECRYPT_BIT] = dec;
        return c;
    endfunction

    function automatic state_t next_phase(input state_t s);
        state_t n;
        n = ST_RESP;
        case (s)
            ST_TEXT: n = ST_CMD;
            ST_CMD:  n = ST_KEY;
            ST_KEY:  n = ST_RECV;
            default: n = ST_RESP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/aes_spi_sequencer_if.sv
// aes_spi_sequencer_if: request, response and byte-link signals of the
// sequencer; slave is the sequencer side, master is the host/link side.
interface aes_spi_sequencer_if #(
    parameter int TEXT_BYTES = 16,
    parameter int KEY_W      = 256
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_decrypt;
    logic [1:0]              req_key_size;
    logic [KEY_W-1:0]        req_key;
    logic [8*TEXT_BYTES-1:0] req_text;

    logic                    tx_start;
    logic [7:0]              tx_byte;
    logic                    link_busy;
    logic                    link_done;
    logic [7:0]              rx_byte;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [8*TEXT_BYTES-1:0] resp_data;
    logic [1:0]              resp_err;

    modport slave (
        input  req_valid, req_decrypt, req_key_size, req_key, req_text,
        output req_ready,
        output tx_start, tx_byte,
        input  link_busy, link_done, rx_byte,
        output resp_valid, resp_data, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_decrypt, req_key_size, req_key, req_text,
        input  req_ready,
        input  tx_start, tx_byte,
        output link_busy, link_done, rx_byte,
        input  resp_valid, resp_data, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/aes_link_watchdog.sv
// aes_link_watchdog: counts cycles since a byte transfer started and flags
// expiry once TIMEOUT cycles pass without a clear.
module aes_link_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;
    logic          armed;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            armed <= 1'b0;
            count <= '0;
        end else if (start) begin
            armed <= 1'b1;
            count <= CW'(1);
        end else if (armed && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = armed && (count == CW'(TIMEOUT));

endmodule

// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: frames one AES request as text, command, key and fill
// bytes over the byte-level SPI master and returns the received block.
module aes_spi_sequencer
    import aes_link_pkg::*;
#(
    parameter int         TEXT_BYTES = 16,
    parameter int         KEY_W      = 256,
    parameter logic [7:0] FILL_BYTE  = 8'h00,
    parameter int         TIMEOUT    = 1024
) (
    input logic                clk,
    input logic                reset,
    aes_spi_sequencer_if.slave bus
);
    localparam int MAX_B  = (TEXT_BYTES > 32) ? TEXT_BYTES : 32;
    localparam int IDX_W  = $clog2(MAX_B) + 1;
    localparam int TEXT_W = 8 * TEXT_BYTES;

    state_t            state, state_d;
    logic [IDX_W-1:0]  idx;
    logic              pend;
    logic              issue, done, abort, accept;
    logic              phase_last, expired;
    logic [7:0]        cur_byte;
    logic [TEXT_W-1:0] text_q, resp_q;
    logic [KEY_W-1:0]  key_q;
    logic              dec_q;
    logic [5:0]        kb_q;
    logic [1:0]        err_q;

    assign accept = (state == ST_IDLE) && bus.req_valid;
    assign done   = bus.link_done && pend;

    always_comb begin
        cur_byte   = 8'h00;
        phase_last = 1'b0;
        unique case (state)
            ST_TEXT: begin
                cur_byte   = text_q[8*(TEXT_BYTES-1-int'(idx)) +: 8];
                phase_last = (idx == IDX_W'(TEXT_BYTES - 1));
            end
            ST_CMD: begin
                cur_byte   = cmd_byte(dec_q, kb_q);
                phase_last = 1'b1;
            end
            ST_KEY: begin
                cur_byte   = key_q[8*(int'(kb_q)-1-int'(idx)) +: 8];
                phase_last = (idx == IDX_W'(kb_q - 6'd1));
            end
            ST_RECV: begin
                cur_byte   = FILL_BYTE;
                phase_last = (idx == IDX_W'(TEXT_BYTES - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // A completing transfer beats a same-cycle timeout expiry.
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        abort   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept)
                    state_d = (bus.req_key_size == KS_BAD) ? ST_RESP : ST_TEXT;
            end
            ST_TEXT, ST_CMD, ST_KEY, ST_RECV: begin
                issue = !pend && !bus.link_busy;
                if (done) begin
                    if (phase_last) state_d = next_phase(state);
                end else if (expired) begin
                    abort   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            pend   <= 1'b0;
            text_q <= '0;
            key_q  <= '0;
            dec_q  <= 1'b0;
            kb_q   <= '0;
            resp_q <= '0;
            err_q  <= ERR_OK;
        end else begin
            if (state_d != state) idx <= '0;
            else if (done)        idx <= idx + 1'b1;

            if (issue)              pend <= 1'b1;
            else if (done || abort) pend <= 1'b0;

            if (accept) begin
                text_q <= bus.req_text;
                key_q  <= bus.req_key;
                dec_q  <= bus.req_decrypt;
                kb_q   <= key_bytes(bus.req_key_size);
                resp_q <= '0;
                err_q  <= (bus.req_key_size == KS_BAD) ? ERR_KEYSIZE : ERR_OK;
            end

            if (state == ST_RECV && done)
                resp_q[8*(TEXT_BYTES-1-int'(idx)) +: 8] <= bus.rx_byte;

            if (abort) err_q <= ERR_TIMEOUT;
        end
    end

    aes_link_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (issue),
        .clear   (done || abort),
        .expired (expired)
    );

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.tx_start   = issue;
    assign bus.tx_byte    = issue ? cur_byte : 8'h00;
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_data  = resp_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// tb_aes_spi_sequencer: directed frames, timing, error paths and reset
// against a small SPI slave model with fixed two-cycle transfers.
module tb_aes_spi_sequencer;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_spi_sequencer_if #(.TEXT_BYTES(16), .KEY_W(256)) bus ();

    aes_spi_sequencer #(
        .TEXT_BYTES (16),
        .KEY_W      (256),
        .FILL_BYTE  (8'h00),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           cyc           = 0;
    int           n_tx          = 0;
    int           last_done_cyc = 0;
    int           stop_at       = -1;
    int           rx_base       = -100;
    logic [127:0] gold          = '0;
    logic [7:0]   tx_log[$];
    int           tx_cyc[$];
    logic         sl_pend       = 1'b0;
    int           sl_cnt        = 0;
    int           n_chk         = 0;
    int           n_pass        = 0;
    int           n_fail        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rx_for(input int i, input int base,
                                          input logic [127:0] blk);
        if (i >= base && i < base + 16) return blk[8*(15-(i-base)) +: 8];
        return 8'hEE;
    endfunction

    // Slave: two-cycle transfer per byte; the byte numbered stop_at never completes.
    always @(posedge clk) begin
        bus.link_done <= 1'b0;
        if (reset) begin
            sl_pend       <= 1'b0;
            bus.link_busy <= 1'b0;
            bus.rx_byte   <= 8'h00;
        end else if (sl_pend) begin
            if (sl_cnt == 0) begin
                sl_pend       <= 1'b0;
                bus.link_busy <= 1'b0;
                bus.link_done <= 1'b1;
                last_done_cyc <= cyc + 1;
            end else begin
                sl_cnt <= sl_cnt - 1;
            end
        end else if (bus.tx_start === 1'b1) begin
            tx_log.push_back(bus.tx_byte);
            tx_cyc.push_back(cyc);
            if (n_tx != stop_at) begin
                sl_pend       <= 1'b1;
                sl_cnt        <= 1;
                bus.link_busy <= 1'b1;
                bus.rx_byte   <= rx_for(n_tx, rx_base, gold);
            end
            n_tx <= n_tx + 1;
        end
    end

    function automatic logic [255:0] log_bytes(input int start, input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[247:0], tx_log[start+i]};
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic dec, input logic [1:0] ks,
                            input logic [255:0] key, input logic [127:0] text,
                            output int acc);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_decrypt  = dec;
        bus.req_key_size = ks;
        bus.req_key      = key;
        bus.req_text     = text;
        for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
        acc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int max, output int rc);
        rc = -1;
        for (int i = 0; i < max; i++) begin
            if (bus.resp_valid === 1'b1) begin
                rc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_resp();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic dec, input logic [1:0] ks,
                             input int k, input int n_exp, input logic [7:0] cmd,
                             input logic [255:0] key, input logic [127:0] text,
                             input logic [127:0] blk);
        int n0, acc, rc;
        logic [255:0] kexp;
        n0      = n_tx;
        gold    = blk;
        rx_base = n0 + 17 + k;
        kexp    = key & ((256'd1 << (8 * k)) - 256'd1);
        send_req(dec, ks, key, text, acc);
        wait_resp(600, rc);
        check({tag, " resp seen"}, 256'(rc >= 0), 256'(1));
        check({tag, " tx count"}, 256'(n_tx - n0), 256'(n_exp));
        check({tag, " first tx"}, 256'(tx_cyc[n0] - acc), 256'(1));
        check({tag, " text"}, log_bytes(n0, 16), 256'(text));
        check({tag, " cmd"}, 256'(tx_log[n0+16]), 256'(cmd));
        check({tag, " key"}, log_bytes(n0 + 17, k), kexp);
        check({tag, " fill"}, log_bytes(n0 + 17 + k, 16), 256'(0));
        check({tag, " data"}, 256'(bus.resp_data), 256'(blk));
        check({tag, " err"}, 256'(bus.resp_err), 256'(0));
        check({tag, " resp lat"}, 256'(rc - last_done_cyc), 256'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0, n1, acc, rc;
        bus.req_valid    = 1'b0;
        bus.req_decrypt  = 1'b0;
        bus.req_key_size = 2'b00;
        bus.req_key      = '0;
        bus.req_text     = '0;
        bus.resp_ready   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst req_ready", 256'(bus.req_ready), 256'(1));
        check("rst tx", 256'({bus.tx_start, bus.tx_byte}), 256'(0));
        check("rst resp", 256'({bus.resp_valid, bus.resp_err}), 256'(0));
        check("rst data", 256'(bus.resp_data), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        // AES-256 encrypt, then 10 cycles of response backpressure
        run_frame("aes256", 1'b0, 2'b10, 32, 65, 8'h20,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h8ea2b7ca516745bfeafc49904b496089);
        for (int i = 0; i < 10; i++) begin
            check("bp data", 256'(bus.resp_data), 256'(128'h8ea2b7ca516745bfeafc49904b496089));
            check("bp ctl", 256'({bus.resp_valid, bus.req_ready, bus.resp_err}), 256'(4'b1000));
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        check("bp same cycle", 256'(bus.req_ready), 256'(0));
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp handover", 256'({bus.req_ready, bus.resp_valid}), 256'(2'b10));

        // AES-128 decrypt; upper key bits must be ignored
        run_frame("aes128d", 1'b1, 2'b00, 16, 49, 8'h90,
                  {128'hffffffffffffffffffffffffffffffff, 128'h000102030405060708090a0b0c0d0e0f},
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff);
        take_resp();

        // Illegal key size
        n0 = n_tx;
        send_req(1'b0, 2'b11, '1, 128'h0123456789abcdef0123456789abcdef, acc);
        check("bad resp lat", 256'(bus.resp_valid === 1'b1 ? cyc - acc : -1), 256'(1));
        check("bad err", 256'(bus.resp_err), 256'(1));
        check("bad data", 256'(bus.resp_data), 256'(0));
        take_resp();
        repeat (3) @(negedge clk);
        check("bad no tx", 256'(n_tx - n0), 256'(0));

        // Timeout: byte 20 never completes
        n0      = n_tx;
        stop_at = n0 + 20;
        rx_base = n0 + 49;
        send_req(1'b0, 2'b10,
                 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                 128'h00112233445566778899aabbccddeeff, acc);
        wait_resp(400, rc);
        check("to resp seen", 256'(rc >= 0), 256'(1));
        check("to lat", 256'(rc - tx_cyc[n0+20]), 256'(TO + 1));
        check("to err", 256'(bus.resp_err), 256'(2));
        check("to data", 256'(bus.resp_data), 256'(0));
        take_resp();
        stop_at = -1;
        repeat (5) @(negedge clk);
        check("to tx count", 256'(n_tx - n0), 256'(21));

        // Reset during byte 5 of KEY on an AES-192 frame
        n0      = n_tx;
        rx_base = n0 + 41;
        send_req(1'b0, 2'b01, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                 128'h00112233445566778899aabbccddeeff, acc);
        for (int i = 0; i < 300 && (n_tx - n0) < 23; i++) @(negedge clk);
        check("mid reach", 256'((n_tx - n0) == 23), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid rst ready", 256'(bus.req_ready), 256'(1));
        check("mid rst tx", 256'({bus.tx_start, bus.tx_byte}), 256'(0));
        check("mid rst resp", 256'({bus.resp_valid, bus.resp_err}), 256'(0));
        check("mid rst data", 256'(bus.resp_data), 256'(0));
        reset = 1'b0;
        n1 = n_tx;
        repeat (6) @(negedge clk);
        check("mid quiet", 256'(n_tx - n1), 256'(0));
        check("mid no resp", 256'(bus.resp_valid), 256'(0));

        run_frame("aes192", 1'b0, 2'b01, 24, 57, 8'h18,
                  256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                  128'h00112233445566778899aabbccddeeff,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        take_resp();
        check("end ready", 256'(bus.req_ready), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
